// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline mode sequencer: mode encoding and
// wait-counter limits used by the RISC-V pipeline control logic.
package pipe_ctrl_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    RUN        = 2'b00,
    FLUSH      = 2'b01,
    MEM_WAIT   = 2'b10,
    INSTR_LOAD = 2'b11
  } modeT;

  localparam int         WAIT_W   = 8;
  localparam logic [7:0] WAIT_MAX = 8'd255;

endpackage

// File: rtl/flush_counter.sv
// Loadable down-counter that times the FLUSH_HOLD window; stops at zero
// and reports it so the sequencer knows when the flush is complete.
module flush_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             isZero
);

  assign isZero = (count == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (en && !isZero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pipe_mode_sequencer.sv
// Pipeline mode controller: sequences RUN / FLUSH / MEM_WAIT / INSTR_LOAD and
// drives the global stall (MASTER_HOLD) and fetch/decode bubble (FLUSH_HOLD).
module pipe_mode_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_DEPTH   = 3,
  parameter int LOAD_WORDS    = 1024,
  parameter int MEM_TIMEOUT   = 255,
  parameter int START_IN_LOAD = 1,
  localparam int AW = $clog2(LOAD_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branchJump,
  input  logic              ramReady,
  input  logic              regWriteCollision,
  input  logic              instrLoadReq,
  input  logic              loadWordValid,
  output logic              MASTER_HOLD,
  output logic              FLUSH_HOLD,
  output logic              LOAD_ACTIVE,
  output logic [AW-1:0]     loadAddr,
  output logic              memTimeout,
  output logic [MODE_W-1:0] modeState
);

  localparam int          FW            = $clog2(FLUSH_DEPTH + 1);
  localparam logic [FW-1:0] FLUSH_START = FW'(FLUSH_DEPTH - 1);
  localparam logic [AW-1:0] LAST_ADDR   = AW'(LOAD_WORDS - 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_AT = WAIT_W'(MEM_TIMEOUT);
  localparam modeT        RESET_MODE    = (START_IN_LOAD != 0) ? INSTR_LOAD : RUN;

  modeT              state, stateNext;
  logic [WAIT_W-1:0] waitCtr, waitNext;
  logic              pendBranch;
  logic              flushLoad, flushEn, flushZero;
  logic              loadAddrClr, loadAddrInc;
  logic              waitStart, waitHold, waitExit;
  logic              timeoutHit;
  logic [FW-1:0]     flushCount;

  flush_counter #(.WIDTH(FW)) flushCounter (
    .clk       (clk),
    .rst       (rst),
    .load      (flushLoad),
    .loadValue (FLUSH_START),
    .en        (flushEn),
    .count     (flushCount),
    .isZero    (flushZero)
  );

  // Frozen while RAM stalls, so a stalled flush still lasts FLUSH_DEPTH ready cycles.
  assign flushEn = (state == FLUSH) && ramReady;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    stateNext   = state;
    flushLoad   = 1'b0;
    loadAddrClr = 1'b0;
    loadAddrInc = 1'b0;
    waitStart   = 1'b0;
    waitHold    = 1'b0;
    waitExit    = 1'b0;
    unique case (state)
      RUN: begin
        if (instrLoadReq) begin
          stateNext   = INSTR_LOAD;
          loadAddrClr = 1'b1;
        end else if (!ramReady) begin
          stateNext = MEM_WAIT;
          waitStart = 1'b1;
        end else if (branchJump) begin
          stateNext = FLUSH;
          flushLoad = 1'b1;
        end
      end
      FLUSH: begin
        if (ramReady && flushZero) stateNext = RUN;
      end
      MEM_WAIT: begin
        if (ramReady) begin
          waitExit = 1'b1;
          if (pendBranch) begin
            stateNext = FLUSH;
            flushLoad = 1'b1;
          end else begin
            stateNext = RUN;
          end
        end else begin
          waitHold = 1'b1;
        end
      end
      INSTR_LOAD: begin
        if (loadWordValid) begin
          if (loadAddr == LAST_ADDR) begin
            stateNext   = FLUSH;
            flushLoad   = 1'b1;
            loadAddrClr = 1'b1;
          end else begin
            loadAddrInc = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    waitNext = waitCtr;
    if (waitStart) begin
      waitNext = WAIT_W'(1);
    end else if (waitExit) begin
      waitNext = '0;
    end else if (waitHold && (waitCtr != WAIT_MAX)) begin
      waitNext = waitCtr + 1'b1;
    end
  end

  // Raised on the edge where the wait count reaches the limit, so the flag is
  // already visible during that wait cycle.
  assign timeoutHit = (waitStart || waitHold) && (waitNext >= TIMEOUT_AT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RESET_MODE;
      loadAddr   <= '0;
      waitCtr    <= '0;
      pendBranch <= 1'b0;
      memTimeout <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCtr <= waitNext;
      if (loadAddrClr) begin
        loadAddr <= '0;
      end else if (loadAddrInc) begin
        loadAddr <= loadAddr + 1'b1;
      end
      if (waitStart) begin
        pendBranch <= branchJump;
      end else if (waitExit) begin
        pendBranch <= 1'b0;
      end
      if (timeoutHit) memTimeout <= 1'b1;
    end
  end

  assign MASTER_HOLD = (state == INSTR_LOAD) || (state == MEM_WAIT) ||
                       ((state == FLUSH) && !ramReady) ||
                       ((state == RUN) && regWriteCollision);
  assign FLUSH_HOLD  = (state == FLUSH);
  assign LOAD_ACTIVE = (state == INSTR_LOAD);
  assign modeState   = state;

endmodule
